slice_edge_event_fifo: RTL

//  Consumes the per-slice synchronised bit vector produced by the two-deep submod register chain
//  (q[i] of the g_slice generate loop). Detects enabled rising/falling edges on each slice bit.

---
 rtl/slice_edge_event_fifo_pkg.sv | 23 ++
 rtl/slice_edge_event_fifo_fifo.sv | 58 +++++
 rtl/slice_edge_event_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/slice_edge_event_fifo_pkg.sv
// Shared types and helpers for the slice edge-event block.
// Default event word layout {rise, fall, ts} and the pointer-width helper.
// Ports: none (package only).
package slice_evt_pkg;

    localparam int DEF_WIDTH  = 2;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DROP_W = 8;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] rise;
        logic [DEF_WIDTH-1:0] fall;
        logic [DEF_TS_W-1:0]  ts;
    } slice_evt_t;

    // One extra pointer bit distinguishes full from empty when the
    // address bits are equal.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/slice_edge_event_fifo_fifo.sv
// Generic synchronous show-ahead FIFO of event words.
// Latency: a push is visible at head_o / !empty_o on the following cycle.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, reset_n (sync, active-low), push_i/push_dat_i, pop_i, full_o, empty_o, head_o.
module slice_evt_fifo
    import slice_evt_pkg::*;
#(
    parameter type T     = slice_evt_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  T     push_dat_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    T              mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // Full + push + pop: the slot being vacated by the pop takes the new word.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign wr_d = do_push ? wr_q + PW'(1) : wr_q;
    assign rd_d = do_pop  ? rd_q + PW'(1) : rd_q;

    assign head_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_dat_i;
            end
        end
    end

endmodule

// File: rtl/slice_edge_event_fifo.sv
// Detects enabled rising/falling edges on synchronised slice bits and queues timestamped events.
// Latency: edge on sync_in in cycle N -> evt_valid in cycle N+1 when the queue was empty.
// Backpressure: evt_valid/evt_ready; a word arriving while full with no pop is dropped and counted.
// Ports: clk, reset_n, sync_in, rise_en, fall_en, evt_valid/evt_ready, evt_rise, evt_fall,
//        evt_ts, overflow, drop_cnt, ovf_clr.
module slice_edge_event_fifo
    import slice_evt_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TS_W   = DEF_TS_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  sync_in,
    input  logic [WIDTH-1:0]  rise_en,
    input  logic [WIDTH-1:0]  fall_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WIDTH-1:0]  evt_rise,
    output logic [WIDTH-1:0]  evt_fall,
    output logic [TS_W-1:0]   evt_ts,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              ovf_clr
);

    // Local layout so non-default widths still pack correctly.
    typedef struct packed {
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic [TS_W-1:0]  ts;
    } evt_t;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]  prev_q;
    logic              armed_q;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    evt_t              push_dat;
    evt_t              head;

    // Until armed, prev_q holds reset zeros, not real history.
    assign rise = armed_q ? (sync_in & ~prev_q & rise_en) : '0;
    assign fall = armed_q ? (~sync_in & prev_q & fall_en) : '0;
    assign push = |{rise, fall};
    assign pop  = evt_valid && evt_ready;
    assign drop = push && full && !pop;

    assign push_dat.rise = rise;
    assign push_dat.fall = fall;
    assign push_dat.ts   = ts_q;

    assign ts_d = ts_q + TS_W'(1);

    // A drop in the same cycle as a clear wins: the new drop is counted from one.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_d = DROP_W'(1);
            end else if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q    <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            ts_q    <= ts_d;
            prev_q  <= sync_in;
            armed_q <= 1'b1;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    slice_evt_fifo #(
        .T     (evt_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head)
    );

    assign evt_valid = !empty;
    assign evt_rise  = head.rise;
    assign evt_fall  = head.fall;
    assign evt_ts    = head.ts;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule
